issue_scheduler: RTL and testbench

Picks which reservation-station entries issue to the three functional units (FU0/FU1 = ALU, FU2 = MEM) each cycle, and tracks FU occupancy. Selection is oldest-first by ROB number, relative to the ROB head so wrap-around is handled. ALU ops bind to any free ALU at issue time instead of at dispatch. The block sits between the dispatch/RS array and the FUs and replaces ad-hoc per-entry issue loops.

---
 rtl/issue_scheduler_pkg.sv | 19 +
 rtl/issue_scheduler_oldest_select.sv | 37 +++
 rtl/issue_scheduler.sv | 157 +++++++++++++++
 tb/tb_issue_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared types and constants for the issue scheduler: FU class encoding,
// MEM unit state encoding and functional-unit numbering.
package issue_scheduler_pkg;

    typedef enum logic [1:0] {
        FU_ALU = 2'b00,
        FU_MEM = 2'b10
    } fu_class_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } mem_sched_state_t;

    localparam int NUM_FU     = 3;
    localparam int FU_MEM_IDX = 2;

endpackage

// File: rtl/issue_scheduler_oldest_select.sv
// Combinational oldest-first picker: finds the requesting entry with the
// smallest ROB age relative to the head; ties resolve to the lower index.
module oldest_select #(
    parameter int N  = 16,
    parameter int AW = 4
) (
    input  logic [N-1:0]            req,
    input  logic [N-1:0][AW-1:0]    age,
    input  logic [AW-1:0]           head,
    output logic                    found,
    output logic [N-1:0]            onehot,
    output logic [$clog2(N)-1:0]    idx
);

    localparam int IW = $clog2(N);

    always_comb begin
        logic [AW-1:0] best;
        logic [AW-1:0] rel;
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        best   = '0;
        rel    = '0;
        for (int i = 0; i < N; i++) begin
            // Modular subtraction makes the head the zero point, so wrap is free.
            rel = age[i] - head;
            if (req[i] && (!found || rel < best)) begin
                found = 1'b1;
                best  = rel;
                idx   = IW'(i);
            end
        end
        onehot[idx] = found;
    end

endmodule

// File: rtl/issue_scheduler.sv
// Per-cycle issue selection for two ALUs and one MEM unit, oldest-first by
// relative ROB age, with ALU occupancy counters and a MEM IDLE/BUSY/GAP FSM.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int RS_DEPTH  = 16,
    parameter int ROB_IDX_W = 4,
    parameter int ALU_LAT   = 1,
    parameter int MEM_GAP   = 1
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic [RS_DEPTH-1:0]                        i_ready,
    input  logic [RS_DEPTH-1:0][1:0]                   i_fu_class,
    input  logic [RS_DEPTH-1:0][ROB_IDX_W-1:0]         i_age,
    input  logic [ROB_IDX_W-1:0]                       i_rob_head,
    input  logic                                       i_flush,
    input  logic                                       i_mem_done,
    output logic [NUM_FU-1:0]                          o_issue_valid,
    output logic [NUM_FU-1:0][$clog2(RS_DEPTH)-1:0]    o_issue_idx,
    output logic [RS_DEPTH-1:0]                        o_clear,
    output logic [NUM_FU-1:0]                          o_fu_free,
    output logic                                       o_proto_err
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [1:0] GAP_LOAD = (MEM_GAP > 0) ? 2'(MEM_GAP - 1) : 2'd0;

    logic [RS_DEPTH-1:0]          alu_req;
    logic [RS_DEPTH-1:0]          mem_req;
    logic [RS_DEPTH-1:0]          rsv_req;
    logic [RS_DEPTH-1:0]          p1_oh, p2_oh, mem_oh;
    logic [IDX_W-1:0]             p1_idx, p2_idx, mem_idx;
    logic                         p1_found, p2_found, mem_found;
    logic [1:0][CNT_W-1:0]        alu_cnt;
    logic [1:0]                   alu_free;
    mem_sched_state_t             mem_state;
    logic [1:0]                   gap_cnt;
    logic                         grant_en;

    always_comb begin
        alu_req = '0;
        mem_req = '0;
        rsv_req = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            alu_req[i] = i_ready[i] && (i_fu_class[i] == FU_ALU);
            mem_req[i] = i_ready[i] && (i_fu_class[i] == FU_MEM);
            rsv_req[i] = i_ready[i] && (i_fu_class[i] != FU_ALU) && (i_fu_class[i] != FU_MEM);
        end
    end

    oldest_select #(.N(RS_DEPTH), .AW(ROB_IDX_W)) u_sel_alu1 (
        .req    (alu_req),
        .age    (i_age),
        .head   (i_rob_head),
        .found  (p1_found),
        .onehot (p1_oh),
        .idx    (p1_idx)
    );

    oldest_select #(.N(RS_DEPTH), .AW(ROB_IDX_W)) u_sel_alu2 (
        .req    (alu_req & ~p1_oh),
        .age    (i_age),
        .head   (i_rob_head),
        .found  (p2_found),
        .onehot (p2_oh),
        .idx    (p2_idx)
    );

    oldest_select #(.N(RS_DEPTH), .AW(ROB_IDX_W)) u_sel_mem (
        .req    (mem_req),
        .age    (i_age),
        .head   (i_rob_head),
        .found  (mem_found),
        .onehot (mem_oh),
        .idx    (mem_idx)
    );

    assign alu_free[0] = (alu_cnt[0] == '0);
    assign alu_free[1] = (alu_cnt[1] == '0);
    assign o_fu_free   = {mem_state == IDLE, alu_free};
    assign grant_en    = i_rst_n && !i_flush;

    // Handshake: o_issue_valid[k] means FU k takes o_issue_idx[k] this cycle;
    // the FU never stalls a grant, since grants are only made while o_fu_free[k].
    always_comb begin
        o_issue_valid = '0;
        o_issue_idx   = '0;
        o_clear       = '0;
        if (grant_en) begin
            if (alu_free[0]) begin
                if (p1_found) begin
                    o_issue_valid[0] = 1'b1;
                    o_issue_idx[0]   = p1_idx;
                    o_clear          = o_clear | p1_oh;
                end
                if (alu_free[1] && p2_found) begin
                    o_issue_valid[1] = 1'b1;
                    o_issue_idx[1]   = p2_idx;
                    o_clear          = o_clear | p2_oh;
                end
            end else if (alu_free[1] && p1_found) begin
                o_issue_valid[1] = 1'b1;
                o_issue_idx[1]   = p1_idx;
                o_clear          = o_clear | p1_oh;
            end
            if (mem_found && mem_state == IDLE && !i_mem_done) begin
                o_issue_valid[FU_MEM_IDX] = 1'b1;
                o_issue_idx[FU_MEM_IDX]   = mem_idx;
                o_clear                   = o_clear | mem_oh;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alu_cnt     <= '0;
            mem_state   <= IDLE;
            gap_cnt     <= '0;
            o_proto_err <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (i_flush)
                    alu_cnt[k] <= '0;
                else if (o_issue_valid[k])
                    alu_cnt[k] <= CNT_W'(ALU_LAT - 1);
                else if (alu_cnt[k] != '0)
                    alu_cnt[k] <= alu_cnt[k] - CNT_W'(1);
            end
            // Flush does not touch the MEM FSM: an in-flight access cannot be cancelled.
            case (mem_state)
                IDLE: if (o_issue_valid[FU_MEM_IDX]) mem_state <= BUSY;
                BUSY: begin
                    if (i_mem_done) begin
                        if (MEM_GAP > 0) begin
                            mem_state <= GAP;
                            gap_cnt   <= GAP_LOAD;
                        end else begin
                            mem_state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 2'd0)
                        mem_state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - 2'd1;
                end
                default: mem_state <= IDLE;
            endcase
            if ((i_mem_done && mem_state != BUSY) || (|rsv_req))
                o_proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: two instances (ALU_LAT 1 and 3) share
// stimulus; expected outputs are queued per driven cycle and compared at negedge.
module tb_issue_scheduler;

    typedef struct packed {
        logic [2:0]  valid;
        logic [3:0]  idx0;
        logic [3:0]  idx1;
        logic [3:0]  idx2;
        logic [15:0] clear;
        logic [2:0]  free;
        logic        err;
        logic        chk3;
        logic [2:0]  free3;
        logic [2:0]  valid3;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic              clk;
    logic              rst_n;
    logic [15:0]       ready;
    logic [15:0][1:0]  cls;
    logic [15:0][3:0]  age;
    logic [3:0]        head;
    logic              flush;
    logic              mem_done;

    logic [2:0]        valid_o, valid3_o;
    logic [2:0][3:0]   idx_o, idx3_o;
    logic [15:0]       clear_o, clear3_o;
    logic [2:0]        free_o, free3_o;
    logic              err_o, err3_o;

    logic [EXP_W-1:0]  exp_q[$];
    int                tests_run;
    int                tests_failed;

    issue_scheduler #(.RS_DEPTH(16), .ROB_IDX_W(4), .ALU_LAT(1), .MEM_GAP(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ready(ready), .i_fu_class(cls),
        .i_age(age), .i_rob_head(head), .i_flush(flush), .i_mem_done(mem_done),
        .o_issue_valid(valid_o), .o_issue_idx(idx_o), .o_clear(clear_o),
        .o_fu_free(free_o), .o_proto_err(err_o)
    );

    issue_scheduler #(.RS_DEPTH(16), .ROB_IDX_W(4), .ALU_LAT(3), .MEM_GAP(1)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ready(ready), .i_fu_class(cls),
        .i_age(age), .i_rob_head(head), .i_flush(flush), .i_mem_done(mem_done),
        .o_issue_valid(valid3_o), .o_issue_idx(idx3_o), .o_clear(clear3_o),
        .o_fu_free(free3_o), .o_proto_err(err3_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] v, input logic [3:0] i0, input logic [3:0] i1,
                                input logic [3:0] i2, input logic [15:0] c, input logic [2:0] f,
                                input logic e);
        exp_t r;
        r        = '0;
        r.valid  = v;
        r.idx0   = i0;
        r.idx1   = i1;
        r.idx2   = i2;
        r.clear  = c;
        r.free   = f;
        r.err    = e;
        return r;
    endfunction

    function automatic exp_t mk3(input exp_t b, input logic [2:0] f3, input logic [2:0] v3);
        exp_t r;
        r        = b;
        r.chk3   = 1'b1;
        r.free3  = f3;
        r.valid3 = v3;
        return r;
    endfunction

    function automatic exp_t quiet(input logic [2:0] f, input logic e);
        return mk(3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, f, e);
    endfunction

    // scoreboard compare
    task automatic compare_out();
        exp_t e;
        e = exp_q.pop_front();
        check_eq("issue_valid", 32'(valid_o),  32'(e.valid));
        check_eq("issue_idx0",  32'(idx_o[0]), 32'(e.idx0));
        check_eq("issue_idx1",  32'(idx_o[1]), 32'(e.idx1));
        check_eq("issue_idx2",  32'(idx_o[2]), 32'(e.idx2));
        check_eq("clear",       32'(clear_o),  32'(e.clear));
        check_eq("fu_free",     32'(free_o),   32'(e.free));
        check_eq("proto_err",   32'(err_o),    32'(e.err));
        if (e.chk3) begin
            check_eq("lat3_fu_free", 32'(free3_o),  32'(e.free3));
            check_eq("lat3_valid",   32'(valid3_o), 32'(e.valid3));
        end
    endtask

    // driver tasks
    task automatic idle_inputs();
        ready    = '0;
        cls      = '0;
        age      = '0;
        head     = '0;
        flush    = 1'b0;
        mem_done = 1'b0;
    endtask

    task automatic expect_cycle(input exp_t e);
        exp_q.push_back(e);
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        idle_inputs();

        // grants suppressed during reset
        ready  = 16'h0006;
        expect_cycle(mk3(quiet(3'b111, 1'b0), 3'b111, 3'b000));
        rst_n = 1'b1;

        // two ALU entries, idx2 older
        idle_inputs();
        ready  = 16'h0006;
        age[1] = 4'd5;
        age[2] = 4'd3;
        expect_cycle(mk(3'b011, 4'd2, 4'd1, 4'd0, 16'h0006, 3'b111, 1'b0));
        idle_inputs();
        expect_cycle(quiet(3'b111, 1'b0));

        // wrap-around: head 14, relative ages idx0=15 idx1=1 idx2=2
        head   = 4'd14;
        age[0] = 4'd13;
        age[1] = 4'd15;
        age[2] = 4'd0;
        ready  = 16'h0007;
        expect_cycle(mk(3'b011, 4'd1, 4'd2, 4'd0, 16'h0006, 3'b111, 1'b0));
        ready  = 16'h0001;
        expect_cycle(mk(3'b001, 4'd0, 4'd0, 4'd0, 16'h0001, 3'b111, 1'b0));
        idle_inputs();
        expect_cycle(quiet(3'b111, 1'b0));

        // MEM: idx7 older than idx4, BUSY then one GAP cycle
        cls[4] = 2'b10;
        cls[7] = 2'b10;
        age[4] = 4'd6;
        age[7] = 4'd2;
        ready  = 16'h0090;
        expect_cycle(mk(3'b100, 4'd0, 4'd0, 4'd7, 16'h0080, 3'b111, 1'b0));
        ready  = 16'h0010;
        expect_cycle(quiet(3'b011, 1'b0));
        expect_cycle(quiet(3'b011, 1'b0));
        mem_done = 1'b1;
        expect_cycle(quiet(3'b011, 1'b0));
        mem_done = 1'b0;
        expect_cycle(quiet(3'b011, 1'b0));
        expect_cycle(mk(3'b100, 4'd0, 4'd0, 4'd4, 16'h0010, 3'b111, 1'b0));
        ready    = 16'h0000;
        mem_done = 1'b1;
        expect_cycle(quiet(3'b011, 1'b0));
        mem_done = 1'b0;
        expect_cycle(quiet(3'b011, 1'b0));
        expect_cycle(quiet(3'b111, 1'b0));

        // ALU_LAT=3 occupancy on the second instance
        idle_inputs();
        ready = 16'h0001;
        expect_cycle(mk3(mk(3'b001, 4'd0, 4'd0, 4'd0, 16'h0001, 3'b111, 1'b0), 3'b111, 3'b001));
        ready = 16'h0002;
        expect_cycle(mk3(mk(3'b001, 4'd1, 4'd0, 4'd0, 16'h0002, 3'b111, 1'b0), 3'b110, 3'b010));
        ready = 16'h0000;
        expect_cycle(mk3(quiet(3'b111, 1'b0), 3'b100, 3'b000));
        expect_cycle(mk3(quiet(3'b111, 1'b0), 3'b101, 3'b000));
        expect_cycle(mk3(quiet(3'b111, 1'b0), 3'b111, 3'b000));

        // flush with MEM BUSY and ready entries
        idle_inputs();
        cls[8] = 2'b10;
        ready  = 16'h0101;
        expect_cycle(mk3(mk(3'b101, 4'd0, 4'd0, 4'd8, 16'h0101, 3'b111, 1'b0), 3'b111, 3'b101));
        flush  = 1'b1;
        cls[9] = 2'b10;
        ready  = 16'h0203;
        expect_cycle(mk3(quiet(3'b011, 1'b0), 3'b010, 3'b000));
        flush  = 1'b0;
        ready  = 16'h0000;
        expect_cycle(mk3(quiet(3'b011, 1'b0), 3'b011, 3'b000));
        expect_cycle(quiet(3'b011, 1'b0));
        mem_done = 1'b1;
        expect_cycle(quiet(3'b011, 1'b0));
        mem_done = 1'b0;
        expect_cycle(quiet(3'b011, 1'b0));
        expect_cycle(quiet(3'b111, 1'b0));

        // mem_done while IDLE: no MEM grant that cycle, sticky error
        idle_inputs();
        cls[4]   = 2'b10;
        ready    = 16'h0010;
        mem_done = 1'b1;
        expect_cycle(quiet(3'b111, 1'b0));
        mem_done = 1'b0;
        expect_cycle(mk(3'b100, 4'd0, 4'd0, 4'd4, 16'h0010, 3'b111, 1'b1));
        ready = 16'h0000;
        expect_cycle(quiet(3'b011, 1'b1));
        expect_cycle(quiet(3'b011, 1'b1));

        // asynchronous reset mid-cycle abandons BUSY and clears the error
        exp_q.push_back(mk3(quiet(3'b111, 1'b0), 3'b111, 3'b000));
        #2 rst_n = 1'b0;
        #1 compare_out();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // reserved class: never granted, raises the error
        idle_inputs();
        cls[0] = 2'b01;
        ready  = 16'h0003;
        expect_cycle(mk(3'b001, 4'd1, 4'd0, 4'd0, 16'h0002, 3'b111, 1'b0));
        idle_inputs();
        expect_cycle(quiet(3'b111, 1'b1));
        expect_cycle(quiet(3'b111, 1'b1));

        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
